uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx_cfg.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding and a 3-sample vote.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_rx
);

  logic r_meta;
  logic r_sync;

  // synchroniser flop chain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
    end
  end

  assign o_rx = r_sync;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: majority-voted bit sampling, optional parity, 1-2 stop bits.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 rx_done_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SMP_A     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] SMP_B     = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] SMP_C     = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD_SENSE = (PARITY_MODE == PARITY_ODD);

  logic                 w_rx;
  logic                 r_rx_d;
  uart_state_e          r_state;
  uart_state_e          w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_bit;
  logic                 r_vote_a;
  logic                 r_vote_b;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_ferr;

  logic w_fall;
  logic w_wrap;
  logic w_decide;
  logic w_vote;
  logic w_load;
  logic w_busy_nxt;
  logic w_ferr_nxt;
  logic w_perr_nxt;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .i_rx (rx_i),
    .o_rx (w_rx)
  );

  assign w_fall   = r_rx_d & ~w_rx;
  assign w_wrap   = (r_cnt == CNT_LAST);
  assign w_decide = (r_cnt == SMP_C);
  assign w_vote   = maj3(r_vote_a, r_vote_b, w_rx);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state decode; the last stop bit leaves on its decision cycle, not at the wrap
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) w_state_nxt = ST_START;
        else        w_state_nxt = ST_IDLE;
      end
      ST_START: begin
        if (w_decide && w_vote) w_state_nxt = ST_IDLE;
        else if (w_wrap)        w_state_nxt = ST_DATA;
        else                    w_state_nxt = ST_START;
      end
      ST_DATA: begin
        if (w_wrap && (r_bit == DATA_LAST))
          w_state_nxt = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
        else
          w_state_nxt = ST_DATA;
      end
      ST_PARITY: begin
        if (w_wrap) w_state_nxt = ST_STOP;
        else        w_state_nxt = ST_PARITY;
      end
      ST_STOP: begin
        if (w_decide && (r_bit == STOP_LAST)) w_state_nxt = ST_DONE;
        else                                  w_state_nxt = ST_STOP;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // output decode: results are captured on entry to DONE so they are valid during DONE
  always_comb begin
    w_load     = (w_state_nxt == ST_DONE);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    if ((r_state == ST_STOP) && w_decide) begin
      w_ferr_nxt = r_ferr | ~w_vote;
    end else begin
      w_ferr_nxt = r_ferr;
    end
    if (PARITY_MODE == PARITY_NONE) begin
      w_perr_nxt = 1'b0;
    end else begin
      w_perr_nxt = (^r_shift) ^ r_par ^ ODD_SENSE;
    end
  end

  // bit timing, sampling, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_d       <= 1'b1;
      r_cnt        <= '0;
      r_bit        <= 4'd0;
      r_vote_a     <= 1'b1;
      r_vote_b     <= 1'b1;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_ferr       <= 1'b0;
      data_o       <= '0;
      rx_done_o    <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      r_rx_d <= w_rx;
      if ((r_state == ST_IDLE) || (w_state_nxt == ST_IDLE) ||
          (w_state_nxt == ST_DONE) || w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_state_nxt != r_state) begin
        r_bit <= 4'd0;
      end else if (w_wrap) begin
        r_bit <= r_bit + 4'd1;
      end else begin
        r_bit <= r_bit;
      end
      if (r_cnt == SMP_A) r_vote_a <= w_rx;
      if (r_cnt == SMP_B) r_vote_b <= w_rx;
      if ((r_state == ST_DATA) && w_decide) begin
        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
      end
      if ((r_state == ST_PARITY) && w_decide) begin
        r_par <= w_vote;
      end
      if (r_state == ST_IDLE) begin
        r_ferr <= 1'b0;
      end else begin
        r_ferr <= w_ferr_nxt;
      end
      rx_done_o <= w_load;
      busy_o    <= w_busy_nxt;
      if (w_load) begin
        data_o       <= r_shift;
        parity_err_o <= w_perr_nxt;
        frame_err_o  <= w_ferr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: frame-level model plus per-cycle output comparison.
module tb_uart_rx_cfg;

  localparam int C = 10;
  localparam int H = C / 2;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_q = 1'b1;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [7:0] d0, d1;
  logic       done0, done1, pe0, pe1, fe0, fe1, b0, b1;

  res_t exp_q0[$];
  res_t exp_q1[$];
  res_t held[2];
  int   n_run = 0;
  int   n_fail = 0;
  int   n_done[2];
  int   n_push[2];

  always #5 clk = ~clk;

  uart_rx_cfg u_np (
    .clk(clk), .rst(rst), .rx_i(rx0), .data_o(d0), .rx_done_o(done0),
    .parity_err_o(pe0), .frame_err_o(fe0), .busy_o(b0)
  );

  uart_rx_cfg #(.PARITY_MODE(1)) u_ep (
    .clk(clk), .rst(rst), .rx_i(rx1), .data_o(d1), .rx_done_o(done1),
    .parity_err_o(pe1), .frame_err_o(fe1), .busy_o(b1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  task automatic cmp_inst(input int i, input logic [7:0] d, input logic dn,
                          input logic pe, input logic fe);
    res_t e;
    if (dn) begin
      n_done[i]++;
      if (i == 0 && exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        held[i] = e;
      end else if (i == 1 && exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        held[i] = e;
      end else begin
        check($sformatf("spurious_done%0d", i), 32'(dn), 32'(1'b0));
      end
    end
    check($sformatf("data%0d", i), 32'(d), 32'(held[i].data));
    check($sformatf("perr%0d", i), 32'(pe), 32'(held[i].pe));
    check($sformatf("ferr%0d", i), 32'(fe), 32'(held[i].fe));
  endtask

  always @(posedge clk) rst_q <= rst;

  // per-cycle comparison against the frame model
  always @(negedge clk) begin
    if (rst_q) begin
      check("reset_out0", 32'({d0, done0, pe0, fe0, b0}), 32'd0);
      check("reset_out1", 32'({d1, done1, pe1, fe1, b1}), 32'd0);
      held[0] = '0;
      held[1] = '0;
    end else begin
      cmp_inst(0, d0, done0, pe0, fe0);
      cmp_inst(1, d1, done1, pe1, fe1);
    end
  end

  // Builds the line waveform, predicts the frame result from it, then drives it.
  task automatic send_frame(input int i, input logic [7:0] data, input bit use_par,
                            input logic par, input logic stop, input int glitch_at);
    logic cells[$];
    logic wave[$];
    logic dec[$];
    res_t e;
    cells.push_back(1'b0);
    for (int k = 0; k < 8; k++) cells.push_back(data[k]);
    if (use_par) cells.push_back(par);
    cells.push_back(stop);
    foreach (cells[j]) begin
      for (int k = 0; k < C; k++) wave.push_back(cells[j]);
    end
    if (glitch_at >= 0) wave[glitch_at] = ~wave[glitch_at];
    // line value reaches the decision logic 1 cycle + synchroniser after the cell starts
    for (int j = 0; j < cells.size(); j++)
      dec.push_back(maj(wave[j*C+H], wave[j*C+H+1], wave[j*C+H+2]));
    for (int k = 0; k < 8; k++) e.data[k] = dec[k+1];
    e.pe = use_par ? ((^e.data) ^ dec[9]) : 1'b0;
    e.fe = ~dec[dec.size()-1];
    if (i == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    n_push[i]++;
    foreach (wave[k]) begin
      @(posedge clk); #1;
      if (i == 0) rx0 = wave[k];
      else        rx1 = wave[k];
    end
  endtask

  task automatic line_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx0 = 1'b1;
      rx1 = 1'b1;
    end
  endtask

  task automatic drain(input int i);
    int k;
    k = 0;
    while (((i == 0) ? exp_q0.size() : exp_q1.size()) != 0 && k < 4*C) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("drain%0d", i), 32'((i == 0) ? exp_q0.size() : exp_q1.size()), 32'd0);
  endtask

  initial begin
    bit saw;
    n_done[0] = 0; n_done[1] = 0;
    n_push[0] = 0; n_push[1] = 0;
    held[0] = '0;  held[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    line_idle(5);

    // plain 0x55 frame, default configuration
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, -1);
    drain(0);
    line_idle(C);
    @(negedge clk);
    check("t1_data", 32'(d0), 32'h55);
    check("t1_flags", 32'({pe0, fe0}), 32'd0);
    check("t1_busy", 32'(b0), 32'd0);

    // even parity: 0xA3 has four ones, so parity 1 is wrong and 0 is right
    send_frame(1, 8'hA3, 1'b1, 1'b1, 1'b1, -1);
    drain(1);
    @(negedge clk);
    check("t2_data", 32'(d1), 32'hA3);
    check("t2_perr_bad", 32'(pe1), 32'd1);
    send_frame(1, 8'hA3, 1'b1, 1'b0, 1'b1, -1);
    drain(1);
    @(negedge clk);
    check("t2_perr_good", 32'(pe1), 32'd0);

    // stop bit held low, then a good frame clears the flag
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, -1);
    line_idle(C);
    drain(0);
    @(negedge clk);
    check("t3_data", 32'(d0), 32'h3C);
    check("t3_ferr", 32'(fe0), 32'd1);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, -1);
    drain(0);
    @(negedge clk);
    check("t3_data2", 32'(d0), 32'h81);
    check("t3_ferr2", 32'(fe0), 32'd0);
    line_idle(C);

    // short low pulse in idle: false start
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 rx0 = 1'b0;
    end
    @(posedge clk); #1 rx0 = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < C - 1; k++) begin
      @(negedge clk);
      if (b0) saw = 1'b1;
    end
    check("t4_busy_rose", 32'(saw), 32'd1);
    check("t4_busy_back", 32'(b0), 32'd0);
    check("t4_no_frame", 32'(d0), 32'h81);
    line_idle(C);

    // one-cycle glitch at the centre sample of data bit 2
    send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1, 3*C + H + 1);
    drain(0);
    @(negedge clk);
    check("t5_data", 32'(d0), 32'hF0);
    line_idle(C);

    // reset during data bit 4 of an all-zero frame
    for (int k = 0; k < 5*C + H; k++) begin
      @(posedge clk); #1 rx0 = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    rx0 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    line_idle(2*C);
    @(negedge clk);
    check("t6_after_rst_data", 32'(d0), 32'h00);
    check("t6_after_rst_busy", 32'(b0), 32'd0);
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, -1);
    drain(0);
    @(negedge clk);
    check("t6_data", 32'(d0), 32'h12);
    line_idle(C);

    // back-to-back frames with no idle gap
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, -1);
    send_frame(0, 8'h34, 1'b0, 1'b0, 1'b1, -1);
    drain(0);
    line_idle(C);
    @(negedge clk);
    check("t7_data", 32'(d0), 32'h34);
    check("pulses0", 32'(n_done[0]), 32'(n_push[0]));
    check("pulses1", 32'(n_done[1]), 32'(n_push[1]));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
